// File: rtl/cfg_stream_loader_pkg.sv
// Shared types and sizing helpers for the configuration stream loader.
package cfg_stream_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_SETTLE,
        ST_DONE
    } state_e;

    // Stream words needed to cover one fabric frame.
    function automatic int wpf(input int frame_w, input int word_w);
        return (frame_w + word_w - 1) / word_w;
    endfunction

    // Bits needed for a counter that runs over 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cfg_frame_assembler.sv
// Packs stream words into one frame-wide shadow register, LSB word first.
module cfg_frame_assembler
    import cfg_stream_loader_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int FRAME_W = 224
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [WORD_W-1:0]  word,
    input  logic               accept,
    input  logic               clear,
    output logic [FRAME_W-1:0] frame,
    output logic               last_word
);

    localparam int WPF      = wpf(FRAME_W, WORD_W);
    localparam int SHADOW_W = WPF * WORD_W;
    localparam int CNT_W    = cnt_w(WPF);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;

    assign last_word = (cnt_q == CNT_W'(WPF - 1));

    // frame includes the word accepted this cycle, so the top can latch a
    // complete frame on the final handshake. Bits above FRAME_W are dropped.
    assign frame = shadow_d[FRAME_W-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned infers a latch.
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (clear) begin
            cnt_d    = '0;
            shadow_d = '0;
        end else if (accept) begin
            for (int k = 0; k < WPF; k++) begin
                if (cnt_q == CNT_W'(k)) shadow_d[k*WORD_W +: WORD_W] = word;
            end
            cnt_d = last_word ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: the shadow is a plain register, not a RAM, so it is cheap to put
    // on the async reset and the fabric never sees stale data after reset.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/cfg_stream_loader.sv
// Streams a configuration bitstream into the fabric frame by frame, then
// settles and enables the fabric flip-flops.
module cfg_stream_loader
    import cfg_stream_loader_pkg::*;
#(
    parameter int WORD_W        = 32,
    parameter int FRAME_W       = 224,
    parameter int NUM_FRAMES    = 43,
    parameter int SETTLE_CYCLES = 10
) (
    input  logic                              clock,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [WORD_W-1:0]                 s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [FRAME_W-1:0]                configs_in,
    output logic [NUM_FRAMES-1:0]             configs_en,
    output logic                              ff_en,
    output logic                              rdy,
    output logic                              busy,
    output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_idx
);

    localparam int IDX_W = $clog2(NUM_FRAMES + 1);
    localparam int SET_W = cnt_w(SETTLE_CYCLES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   frame_idx_q, frame_idx_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [FRAME_W-1:0] configs_in_q, configs_in_d;
    logic               ff_en_q, ff_en_d;
    logic               rdy_q, rdy_d;
    logic               accept, asm_clear, last_word;
    logic [FRAME_W-1:0] asm_frame;

    // abort gates s_ready so an in-flight word is left with the source.
    assign s_ready = (state_q == ST_LOAD) && !abort;
    assign accept  = s_ready && s_valid;

    cfg_frame_assembler #(
        .WORD_W  (WORD_W),
        .FRAME_W (FRAME_W)
    ) u_asm (
        .clock     (clock),
        .rst       (rst),
        .word      (s_data),
        .accept    (accept),
        .clear     (asm_clear),
        .frame     (asm_frame),
        .last_word (last_word)
    );

    always_comb begin
        state_d      = state_q;
        frame_idx_d  = frame_idx_q;
        settle_d     = settle_q;
        configs_in_d = configs_in_q;
        ff_en_d      = ff_en_q;
        rdy_d        = rdy_q;
        asm_clear    = 1'b0;
        if (abort) begin
            state_d      = ST_IDLE;
            frame_idx_d  = '0;
            settle_d     = '0;
            configs_in_d = '0;
            ff_en_d      = 1'b0;
            rdy_d        = 1'b0;
            asm_clear    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d     = ST_LOAD;
                        frame_idx_d = '0;
                        ff_en_d     = 1'b0;
                        rdy_d       = 1'b0;
                        asm_clear   = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept && last_word) begin
                        configs_in_d = asm_frame;
                        state_d      = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    frame_idx_d = frame_idx_q + IDX_W'(1);
                    if (frame_idx_q == IDX_W'(NUM_FRAMES - 1)) begin
                        state_d  = ST_SETTLE;
                        settle_d = SET_W'(SETTLE_CYCLES - 1);
                        ff_en_d  = (SETTLE_CYCLES == 1);
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_SETTLE: begin
                    // ff_en is live during the final settle cycle, rdy follows.
                    if (settle_q == '0) begin
                        state_d = ST_DONE;
                        rdy_d   = 1'b1;
                    end else begin
                        settle_d = settle_q - SET_W'(1);
                        ff_en_d  = (settle_q == SET_W'(1));
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            frame_idx_q  <= '0;
            settle_q     <= '0;
            configs_in_q <= '0;
            ff_en_q      <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_idx_q  <= frame_idx_d;
            settle_q     <= settle_d;
            configs_in_q <= configs_in_d;
            ff_en_q      <= ff_en_d;
            rdy_q        <= rdy_d;
        end
    end

    always_comb begin
        configs_en = '0;
        if (state_q == ST_WRITE) configs_en = NUM_FRAMES'(1) << frame_idx_q;
    end

    assign configs_in = configs_in_q;
    assign ff_en      = ff_en_q;
    assign rdy        = rdy_q;
    assign frame_idx  = frame_idx_q;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_WRITE) ||
                        (state_q == ST_SETTLE);

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Scoreboard bench for cfg_stream_loader: 8-bit words, 20-bit frames, 3 frames.
module tb_cfg_stream_loader;

    logic        clock = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [19:0] configs_in;
    logic [2:0]  configs_en;
    logic        ff_en;
    logic        rdy;
    logic        busy;
    logic [1:0]  frame_idx;

    cfg_stream_loader #(
        .WORD_W        (8),
        .FRAME_W       (20),
        .NUM_FRAMES    (3),
        .SETTLE_CYCLES (4)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .configs_in (configs_in),
        .configs_en (configs_en),
        .ff_en      (ff_en),
        .rdy        (rdy),
        .busy       (busy),
        .frame_idx  (frame_idx)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  en;
        logic [19:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   ff_rise = -1;
    logic prev_ff = 1'b0;

    logic [7:0]  words [9]      = '{8'h11, 8'h22, 8'h3F, 8'h44, 8'h55, 8'h66,
                                    8'h77, 8'h88, 8'h99};
    logic [19:0] exp_frames [3] = '{20'hF2211, 20'h65544, 20'h98877};

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe cycle pops one expected frame write.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (rst) begin
            if (ff_en && !prev_ff) ff_rise = cyc;
            prev_ff = ff_en;
            if (configs_en !== 3'b000) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", 64'(configs_en), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("configs_en", 64'(configs_en), 64'(e.en));
                    check("configs_in", 64'(configs_in), 64'(e.data));
                    check("write_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end else begin
            prev_ff = 1'b0;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_configs_in"}, 64'(configs_in), 64'd0);
        check({tag, "_configs_en"}, 64'(configs_en), 64'd0);
        check({tag, "_s_ready"},    64'(s_ready),    64'd0);
        check({tag, "_ff_en"},      64'(ff_en),      64'd0);
        check({tag, "_rdy"},        64'(rdy),        64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_frame_idx"},  64'(frame_idx),  64'd0);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Present one word and wait (bounded) for its handshake; acc = accept cycle.
    task automatic send_word(input logic [7:0] w, input bit gap, input bit inj,
                             output int acc);
        int budget = 0;
        if (gap) begin
            @(negedge clock);
            s_valid = 1'b0;
            start   = inj;
        end
        @(negedge clock);
        s_valid = 1'b1;
        s_data  = w;
        start   = inj;
        #1;
        while (!s_ready) begin
            budget++;
            if (budget > 50) begin
                check("accept_timeout", 64'd0, 64'd1);
                acc = -1;
                return;
            end
            @(negedge clock);
            #1;
        end
        acc = cyc;
    endtask

    task automatic wait_done(input int first, input int last_wr);
        int n = 0;
        int rdy_cyc;
        while (!rdy) begin
            @(negedge clock);
            n++;
            if (n > 100) begin
                check("rdy_timeout", 64'd0, 64'd1);
                return;
            end
        end
        rdy_cyc = cyc;
        if (first >= 0) check("load_cycles", 64'(rdy_cyc - first), 64'd16);
        check("ff_en_rise", 64'(ff_rise), 64'(last_wr + 4));
        check("rdy_rise", 64'(rdy_cyc), 64'(last_wr + 5));
        check("done_frame_idx", 64'(frame_idx), 64'd3);
        check("done_busy", 64'(busy), 64'd0);
        check("done_ff_en", 64'(ff_en), 64'd1);
    endtask

    task automatic load_stream(input bit gap, input bit inj, input bit ones,
                               input bit wait_rdy);
        int   acc;
        int   first   = -1;
        int   last_wr = 0;
        exp_t e;
        ff_rise = -1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 3; k++) begin
                send_word(ones ? 8'hFF : words[f*3+k], gap, inj, acc);
                if (f == 0 && k == 0) first = acc;
                if (k == 2) begin
                    e.en    = 3'(1 << f);
                    e.data  = ones ? 20'hFFFFF : exp_frames[f];
                    e.cyc   = acc + 1;
                    last_wr = acc + 1;
                    sb_q.push_back(e);
                end
            end
        end
        @(negedge clock);
        s_valid = 1'b0;
        start   = 1'b0;
        if (wait_rdy) wait_done(gap ? -1 : first, last_wr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int   acc;
        exp_t e;
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        rst = 1'b1;

        // Continuous stream.
        pulse_start();
        load_stream(1'b0, 1'b0, 1'b0, 1'b1);

        // Stalled stream, s_valid every other cycle.
        pulse_start();
        load_stream(1'b1, 1'b0, 1'b0, 1'b1);

        // Abort on the second word of frame 1.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_word(words[i], 1'b0, 1'b0, acc);
            if (i == 2) begin
                e.en   = 3'b001;
                e.data = exp_frames[0];
                e.cyc  = acc + 1;
                sb_q.push_back(e);
            end
        end
        @(negedge clock);
        s_data  = words[4];
        s_valid = 1'b1;
        abort   = 1'b1;
        #1;
        check("abort_s_ready", 64'(s_ready), 64'd0);
        @(negedge clock);
        abort   = 1'b0;
        s_valid = 1'b0;
        check_idle_outputs("abort");
        pulse_start();
        load_stream(1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of SETTLE.
        pulse_start();
        load_stream(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        check("settle_busy", 64'(busy), 64'd1);
        #3 rst = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clock);
        rst = 1'b1;
        pulse_start();
        load_stream(1'b0, 1'b0, 1'b0, 1'b1);

        // Reconfigure from DONE with all-ones words.
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("reload_ff_en", 64'(ff_en), 64'd0);
        check("reload_rdy", 64'(rdy), 64'd0);
        check("reload_configs_in", 64'(configs_in), 64'h98877);
        check("reload_frame_idx", 64'(frame_idx), 64'd0);
        check("reload_busy", 64'(busy), 64'd1);
        load_stream(1'b0, 1'b0, 1'b1, 1'b1);

        // start held high through LOAD and WRITE must be ignored.
        pulse_start();
        load_stream(1'b0, 1'b1, 1'b0, 1'b1);

        repeat (2) @(negedge clock);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
